// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm -- calculator key-entry controller.
//
// Consumes key events from the keypad scanner, assembles BCD operands A and
// B, latches the operator, hands the operation to the arithmetic unit over a
// valid/ready request and shows the returned result.
//
// Optional feature: define CALC_CHAIN_EN to let an operator key typed after
// operand B launch the pending operation and chain its result into operand A.
//
// Ports:
//   CLK, RESET      clock (rising edge), asynchronous active-high reset
//   BCDKey, KeyRead key code ([0:3], bit 0 = MSB) and key-valid from scanner
//   OpA, OpB        BCD operands, most significant digit in the top nibble
//   OpCode          00 add, 01 sub, 10 mul, 11 div
//   OpValid/OpReady request handshake to the arithmetic unit
//   ResultBCD/ResultValid/ResultErr  result strobe from the arithmetic unit
//   DispBCD/DispErr value and error flag for the display driver
//   Busy            high while a request is outstanding
module calc_entry_fsm #(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [0:3]           BCDKey,
    input  logic                 KeyRead,
    output logic [4*NDIGITS-1:0] OpA,
    output logic [4*NDIGITS-1:0] OpB,
    output logic [1:0]           OpCode,
    output logic                 OpValid,
    input  logic                 OpReady,
    input  logic [4*NDIGITS-1:0] ResultBCD,
    input  logic                 ResultValid,
    input  logic                 ResultErr,
    output logic [4*NDIGITS-1:0] DispBCD,
    output logic                 DispErr,
    output logic                 Busy
);

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(NDIGITS);

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_REQ,
        S_WAIT,
        S_SHOW
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [1:0]      opcode_q, opcode_d;
    logic [CW-1:0]   cnta_q, cnta_d;
    logic [CW-1:0]   cntb_q, cntb_d;
    logic            err_q, err_d;
    logic            kr_q;
`ifdef CALC_CHAIN_EN
    logic [1:0]      pend_q, pend_d;
    logic            chain_q, chain_d;
`endif

    logic [3:0] key;
    logic       key_ev;
    logic       is_digit, is_op, is_eq, is_clr;
    logic [1:0] op_key;

    assign key      = BCDKey;
    assign key_ev   = KeyRead & ~kr_q;
    assign is_digit = (key <= 4'd9);
    assign is_op    = (key >= 4'd10) && (key <= 4'd13);
    assign is_eq    = (key == 4'd14);
    assign is_clr   = (key == 4'd15);
    // Keys 10..13 are 101x/110x: {bit2, bit0} yields 00..11 directly.
    assign op_key   = {key[2], key[0]};

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opcode_d = opcode_q;
        cnta_d   = cnta_q;
        cntb_d   = cntb_q;
        err_d    = err_q;
`ifdef CALC_CHAIN_EN
        pend_d   = pend_q;
        chain_d  = chain_q;
`endif
        if (key_ev && is_clr) begin
            state_d  = S_ENTER_A;
            opa_d    = '0;
            opb_d    = '0;
            opcode_d = '0;
            cnta_d   = '0;
            cntb_d   = '0;
            err_d    = 1'b0;
`ifdef CALC_CHAIN_EN
            pend_d   = '0;
            chain_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (key_ev) begin
                        if (is_digit) begin
                            if (cnta_q < CMAX) begin
                                opa_d  = {opa_q[W-5:0], key};
                                cnta_d = cnta_q + CW'(1);
                            end
                        end else if (is_op) begin
                            opcode_d = op_key;
                            opb_d    = '0;
                            cntb_d   = '0;
                            state_d  = S_ENTER_B;
                        end
                    end
                end
                S_ENTER_B: begin
                    if (key_ev) begin
                        if (is_digit) begin
                            if (cntb_q < CMAX) begin
                                opb_d  = {opb_q[W-5:0], key};
                                cntb_d = cntb_q + CW'(1);
                            end
                        end else if (is_op) begin
                            if (cntb_q == '0) begin
                                opcode_d = op_key;
                            end else begin
`ifdef CALC_CHAIN_EN
                                // Launch with the current operator; the new one waits.
                                pend_d  = op_key;
                                chain_d = 1'b1;
                                state_d = S_REQ;
`else
                                opcode_d = op_key;
`endif
                            end
                        end else if (is_eq && (cntb_q != '0)) begin
`ifdef CALC_CHAIN_EN
                            chain_d = 1'b0;
`endif
                            state_d = S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (OpReady) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ResultValid) begin
                        opa_d = ResultBCD;
                        err_d = ResultErr;
`ifdef CALC_CHAIN_EN
                        chain_d = 1'b0;
                        if (chain_q && !ResultErr) begin
                            opcode_d = pend_q;
                            opb_d    = '0;
                            cntb_d   = '0;
                            state_d  = S_ENTER_B;
                        end else begin
                            state_d = S_SHOW;
                        end
`else
                        state_d = S_SHOW;
`endif
                    end
                end
                S_SHOW: begin
                    if (key_ev) begin
                        if (is_digit) begin
                            opa_d   = {{(W-4){1'b0}}, key};
                            cnta_d  = CW'(1);
                            err_d   = 1'b0;
                            state_d = S_ENTER_A;
                        end else if (is_op && !err_q) begin
                            opcode_d = op_key;
                            opb_d    = '0;
                            cntb_d   = '0;
                            state_d  = S_ENTER_B;
                        end
                    end
                end
                default: state_d = S_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_ENTER_A;
            opa_q    <= '0;
            opb_q    <= '0;
            opcode_q <= '0;
            cnta_q   <= '0;
            cntb_q   <= '0;
            err_q    <= 1'b0;
            kr_q     <= 1'b0;
`ifdef CALC_CHAIN_EN
            pend_q   <= '0;
            chain_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opcode_q <= opcode_d;
            cnta_q   <= cnta_d;
            cntb_q   <= cntb_d;
            err_q    <= err_d;
            kr_q     <= KeyRead;
`ifdef CALC_CHAIN_EN
            pend_q   <= pend_d;
            chain_q  <= chain_d;
`endif
        end
    end

    // OpValid decodes straight from the state so reset and CLEAR drop it at once.
    assign OpA     = opa_q;
    assign OpB     = opb_q;
    assign OpCode  = opcode_q;
    assign OpValid = (state_q == S_REQ);
    assign Busy    = (state_q == S_REQ) || (state_q == S_WAIT);
    assign DispErr = err_q;

    always_comb begin
        DispBCD = opa_q;
        case (state_q)
            S_ENTER_B:      DispBCD = (cntb_q != '0) ? opb_q : opa_q;
            S_REQ, S_WAIT:  DispBCD = opb_q;
            default:        DispBCD = opa_q;
        endcase
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: a decimal-arithmetic reference model
// predicts the display after every key/result and every ALU request; a
// monitor pops and compares when the DUT acts on an event or hands off a request.
module tb_calc_entry_fsm;

    localparam int ND = 4;
    localparam int M_A = 0, M_B = 1, M_REQ = 2, M_WAIT = 3, M_SHOW = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [0:3]  BCDKey = '0;
    logic        KeyRead = 1'b0;
    logic [15:0] OpA, OpB, DispBCD;
    logic [1:0]  OpCode;
    logic        OpValid, DispErr, Busy;
    logic        OpReady = 1'b0;
    logic [15:0] ResultBCD = '0;
    logic        ResultValid = 1'b0;
    logic        ResultErr = 1'b0;

    calc_entry_fsm #(.NDIGITS(ND)) dut (
        .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead),
        .OpA(OpA), .OpB(OpB), .OpCode(OpCode), .OpValid(OpValid),
        .OpReady(OpReady), .ResultBCD(ResultBCD), .ResultValid(ResultValid),
        .ResultErr(ResultErr), .DispBCD(DispBCD), .DispErr(DispErr), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int opv_cnt = 0;

    // Reference model state: operands as plain decimal integers.
    int mode, a, an, b, bn, op, err, pend, chain;

    logic [18:0] exp_q[$];   // {disp, err, busy, opvalid}
    logic [33:0] req_q[$];   // {A, B, opcode}

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [18:0] exp_now();
        int d;
        case (mode)
            M_B:           d = (bn > 0) ? b : a;
            M_REQ, M_WAIT: d = b;
            default:       d = a;
        endcase
        return {to_bcd(d), err[0], (mode == M_REQ || mode == M_WAIT), (mode == M_REQ)};
    endfunction

    task automatic model_reset();
        mode = M_A; a = 0; an = 0; b = 0; bn = 0; op = 0; err = 0; pend = 0; chain = 0;
    endtask

    task automatic model_key(input int k);
        if (k == 15) begin
            if (mode == M_REQ) void'(req_q.pop_back());
            model_reset();
        end else begin
            case (mode)
                M_A: begin
                    if (k < 10) begin
                        if (an < ND) begin a = a * 10 + k; an++; end
                    end else if (k < 14) begin
                        op = k - 10; b = 0; bn = 0; mode = M_B;
                    end
                end
                M_B: begin
                    if (k < 10) begin
                        if (bn < ND) begin b = b * 10 + k; bn++; end
                    end else if (k < 14) begin
                        if (bn == 0) op = k - 10;
                        else begin
`ifdef CALC_CHAIN_EN
                            pend = k - 10; chain = 1;
                            req_q.push_back({to_bcd(a), to_bcd(b), 2'(op)});
                            mode = M_REQ;
`else
                            op = k - 10;
`endif
                        end
                    end else if (bn > 0) begin
                        chain = 0;
                        req_q.push_back({to_bcd(a), to_bcd(b), 2'(op)});
                        mode = M_REQ;
                    end
                end
                M_SHOW: begin
                    if (k < 10) begin
                        a = k; an = 1; err = 0; mode = M_A;
                    end else if (k < 14 && err == 0) begin
                        op = k - 10; b = 0; bn = 0; mode = M_B;
                    end
                end
                default: ;
            endcase
        end
        exp_q.push_back(exp_now());
    endtask

    task automatic model_result(input int r, input int e);
        if (mode == M_WAIT) begin
            a = r;
            err = e;
            if (chain != 0 && e == 0) begin
                op = pend; b = 0; bn = 0; mode = M_B;
            end else begin
                mode = M_SHOW;
            end
            chain = 0;
        end
        exp_q.push_back(exp_now());
    endtask

    // Stimulus tasks start and end 1 time unit after a rising edge.
    task automatic press(input int k, input int hold);
        @(posedge CLK); #1;
        BCDKey = 4'(k);
        KeyRead = 1'b1;
        model_key(k);
        repeat (hold) @(posedge CLK);
        #1 KeyRead = 1'b0;
    endtask

    task automatic send_result(input int r, input int e);
        @(posedge CLK); #1;
        ResultBCD = to_bcd(r);
        ResultErr = e[0];
        ResultValid = 1'b1;
        model_result(r, e);
        @(posedge CLK); #1;
        ResultValid = 1'b0;
        ResultErr = 1'b0;
    endtask

    task automatic do_request(input int low);
        repeat (low) @(posedge CLK);
        #1 OpReady = 1'b1;
        @(posedge CLK); #1;
        OpReady = 1'b0;
        mode = M_WAIT;
    endtask

    function automatic int pick_key();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return $urandom_range(0, 9);
        if (r < 78) return $urandom_range(10, 13);
        if (r < 95) return 14;
        return 15;
    endfunction

    // Monitor: note events at the edge, compare on the falling edge.
    logic kprev = 1'b0;
    logic ev_pending = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            kprev <= 1'b0;
            ev_pending <= 1'b0;
        end else begin
            ev_pending <= (KeyRead && !kprev) || ResultValid;
            kprev <= KeyRead;
        end
    end

    always @(negedge CLK) begin
        if (OpValid) opv_cnt++;
        if (ev_pending && !RESET) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL disp_unexpected: got %h with no expected entry", DispBCD);
            end else begin
                check("disp_err_busy_valid", {DispBCD, DispErr, Busy, OpValid}, exp_q.pop_front());
            end
        end
        if (OpValid && OpReady && !RESET) begin
            if (req_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL req_unexpected: got %h %h %b with no expected request", OpA, OpB, OpCode);
            end else begin
                check("request", {OpA, OpB, OpCode}, req_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0t limit 200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        model_reset();
        #10 RESET = 1'b0;
        #1;
        check("reset_state", {OpA, OpB, OpCode, OpValid, DispBCD, DispErr, Busy}, '0);

        press(1, 5); press(2, 1); press(3, 2);
        check("disp_0123", DispBCD, 16'h0123);
        press(4, 1); press(5, 1);
        check("opa_1234", OpA, 16'h1234);

        press(15, 1); press(7, 1); press(10, 1); press(5, 1);
        opv_cnt = 0;
        press(14, 1);
        do_request(3);
        check("opvalid_cycles", opv_cnt, 4);
        send_result(12, 0);
        check("disp_0012", DispBCD, 16'h0012);

        press(11, 1); press(2, 1); press(14, 1);
        do_request(0);
        send_result(77, 1);
        check("disperr_set", DispErr, 1'b1);
        press(11, 1);
        press(4, 1);
        check("disp_after_err", {DispBCD, DispErr}, {16'h0004, 1'b0});

        press(3, 1); press(10, 1); press(4, 1); press(14, 1);
        do_request(1);
        press(15, 1);
        send_result(99, 0);
        check("clear_in_wait", {DispBCD, OpValid}, {16'h0000, 1'b0});

        for (int s = 0; s < 400; s++) begin
            case (mode)
                M_REQ: begin
                    r = $urandom_range(0, 9);
                    if (r == 0) press(15, $urandom_range(1, 3));
                    else if (r == 1) press($urandom_range(0, 14), 1);
                    else do_request($urandom_range(0, 3));
                end
                M_WAIT: begin
                    r = $urandom_range(0, 9);
                    if (r == 0) press(15, 1);
                    else if (r == 1) press($urandom_range(0, 14), 2);
                    else send_result($urandom_range(0, 9999), ($urandom_range(0, 5) == 0) ? 1 : 0);
                end
                default: begin
                    if ($urandom_range(0, 29) == 0) send_result($urandom_range(0, 9999), 0);
                    else press(pick_key(), $urandom_range(1, 4));
                end
            endcase
        end

        press(15, 1); press(6, 1); press(12, 1); press(8, 1); press(14, 1);
        @(posedge CLK);
        #1 RESET = 1'b1;
        #1 check("async_reset_mid_req", {OpValid, Busy, DispBCD}, '0);
        #1 RESET = 1'b0;
        req_q.delete();
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Sits directly downstream of the keypad scanner and consumes its `BCDKey` / `KeyRead` strobe.
- Assembles multi-digit BCD operands and latches the operator.
- Issues a valid/ready request to the arithmetic unit and accepts its result.
- Drives the value to be displayed: the operand being typed or the last result.

Parameters:
- NDIGITS, 4, number of BCD digits per operand/result. Operand width W = 4*NDIGITS.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high; clears all state.
- BCDKey  in  4  key code from the scanner, declared [0:3], bit 0 = MSB.
- KeyRead  in  1  key-valid from the scanner; acted on at its rising edge only.
- OpA  out  W  operand A, BCD, most significant digit in top nibble.
- OpB  out  W  operand B, BCD.
- OpCode  out  2  00 add, 01 sub, 10 mul, 11 div.
- OpValid  out  1  request to ALU; held until accepted.
- OpReady  in  1  ALU accept.
- ResultBCD  in  W  ALU result.
- ResultValid  in  1  one-cycle result strobe.
- ResultErr  in  1  qualifies ResultValid (overflow/div0).
- DispBCD  out  W  value for the display driver.
- DispErr  out  1  error indicator for the display.
- Busy  out  1  high in REQ and WAIT.

Behaviour:
Key codes:
- 0-9 digit; 10 ADD; 11 SUB; 12 MUL; 13 DIV; 14 EQUALS; 15 CLEAR.

Key event detection:
- A key event occurs at a rising CLK edge where KeyRead=1 and the registered previous KeyRead=0.
- BCDKey is sampled on that same edge.
- The event's effect is visible on outputs after that edge (latency 1 cycle).
- Holding KeyRead high produces exactly one event.

Reset values:
- State ENTER_A, OpA=OpB=0, OpCode=00, OpValid=0, DispBCD=0, DispErr=0, Busy=0.
- Digit counters = 0; prev-KeyRead = 0.

States:
- ENTER_A
  - Digit: if cntA<NDIGITS, OpA <= {OpA[W-5:0], digit} and cntA++; at NDIGITS digits further digits are ignored.
  - Operator: OpCode latched, OpB=0, cntB=0, go to ENTER_B. With no digits typed, A=0.
  - EQUALS ignored.
  - DispBCD=OpA.
- ENTER_B
  - Digits shift into OpB with the same rules, using cntB.
  - Operator with cntB=0: replaces OpCode.
  - EQUALS with cntB=0: ignored.
  - EQUALS with cntB>0: go to REQ.
  - DispBCD = OpB if cntB>0, else OpA.
- REQ
  - OpValid=1; OpA/OpB/OpCode held stable.
  - On an edge with OpReady=1: OpValid<=0, go to WAIT.
  - If OpReady is already high on REQ entry, the transfer completes at the first REQ edge.
- WAIT
  - On ResultValid: OpA<=ResultBCD, DispErr<=ResultErr, go to SHOW.
  - ResultValid outside WAIT is ignored.
- SHOW
  - DispBCD=OpA (the result).
  - Digit: OpA<=digit, cntA=1, DispErr=0, go to ENTER_A.
  - Operator: if DispErr=0, the result becomes operand A and the flow continues as in ENTER_A. If DispErr=1, the operator is ignored.
  - EQUALS ignored.

CLEAR (any state):
- Returns to the reset values.
- In REQ: deasserts OpValid immediately.
- In WAIT: a later ResultValid is ignored.

Key events in REQ/WAIT:
- All keys except CLEAR are ignored.

Reset mid-operation:
- Asynchronous; OpValid drops without waiting for the handshake.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- When defined, in ENTER_B with cntB>0:
  - An operator key launches REQ with the current OpCode and stores the new operator as pending.
  - On a non-error result: OpA<=ResultBCD, OpCode<=pending, OpB=0, cntB=0, go directly to ENTER_B.
  - On an error result: go to SHOW with DispErr=1 and discard the pending operator.
- When undefined: an operator in ENTER_B with cntB>0 only replaces OpCode (digits kept); no pending register is synthesized.

Test Plan:
- RESET pulse 10 ns, keys 1,2,3 -> DispBCD=0x0123, state ENTER_A; KeyRead held 5 cycles yields one digit.
- Keys 1,2,3,4,5 (NDIGITS=4) -> OpA=0x1234; fifth digit ignored.
- Keys 7, ADD, 5, EQUALS; OpReady low 3 cycles then high -> OpValid high exactly 4 cycles, OpA=0x0007, OpB=0x0005, OpCode=00, Busy=1. Then ResultValid with 0x0012 -> DispBCD=0x0012, state SHOW.
- Result with ResultErr=1 -> DispErr=1; key SUB ignored; digit 4 -> DispBCD=0x0004, DispErr=0.
- CLEAR during WAIT followed by ResultValid=0x0099 -> DispBCD=0, OpValid=0, result ignored. Async RESET asserted mid-REQ clears OpValid without a clock edge.
- CALC_CHAIN_EN: keys 2, ADD, 3, MUL, 4, EQUALS with ALU returning 0x0005 then 0x0020 -> second request OpA=0x0005, OpB=0x0004, OpCode=10; final DispBCD=0x0020.
